// File: rtl/vout_udpoti_setpoint.sv
`timescale 1ns/1ps
// Setpoint conditioning ahead of the up/down pot driver: clamp, deadband,
// slew-rate limit and a host-silence watchdog that falls back to a safe value.
module vout_udpoti_setpoint #(
    parameter int unsigned RESOLUTION = 100,
    parameter int unsigned SLEW_DIV   = 200000,
    parameter int unsigned DEADBAND   = 0,
    parameter int unsigned TIMEOUT    = 50000000,
    parameter int unsigned SAFE_VALUE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] setpoint,
    input  logic        setpoint_valid,
    output logic [31:0] value,
    output logic        at_target,
    output logic        clamped,
    output logic        fault
);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [31:0] RES_MAX   = 32'(RESOLUTION);
    localparam logic [31:0] SAFE      = 32'(SAFE_VALUE);
    localparam logic [31:0] SLEW_LAST = 32'(SLEW_DIV - 1);
    localparam logic [31:0] TMO       = 32'(TIMEOUT);
    localparam logic [32:0] DB        = 33'(DEADBAND);

    state_t      state, state_next;
    logic [31:0] target, target_next;
    logic [31:0] value_next;
    logic        clamped_next;
    logic        fault_next;
    logic [31:0] wd_cnt, wd_next;
    logic [31:0] slew_cnt, slew_next;
    logic        tick;

    logic [31:0] sat;
    logic        sat_hit;
    logic [32:0] diff;
    logic [32:0] diff_mag;
    logic        outside_band;

    // Bit 31 set means a negative setpoint; otherwise it is safe to compare unsigned.
    always_comb begin
        sat = setpoint;
        if (setpoint[31]) begin
            sat = '0;
        end else if (setpoint > RES_MAX) begin
            sat = RES_MAX;
        end
    end

    assign sat_hit      = (sat != setpoint);
    assign diff         = {1'b0, sat} - {1'b0, target};
    assign diff_mag     = diff[32] ? (33'd0 - diff) : diff;
    assign outside_band = (diff_mag > DB);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        target_next  = target;
        clamped_next = clamped;
        fault_next   = fault;
        wd_next      = wd_cnt;

        case (state)
            ST_RUN: begin
                if (setpoint_valid) begin
                    wd_next = '0;
                    if (outside_band) begin
                        target_next  = sat;
                        clamped_next = sat_hit;
                    end
                end else if (TMO != '0) begin
                    if (wd_cnt + 32'd1 == TMO) begin
                        state_next  = ST_FAULT;
                        target_next = SAFE;
                        fault_next  = 1'b1;
                        wd_next     = '0;
                    end else begin
                        wd_next = wd_cnt + 32'd1;
                    end
                end
            end
            ST_FAULT: begin
                // Recovery write bypasses the deadband so the host regains control at once.
                if (setpoint_valid) begin
                    state_next   = ST_RUN;
                    target_next  = sat;
                    clamped_next = sat_hit;
                    fault_next   = 1'b0;
                    wd_next      = '0;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Free-running slew phase; a step compares against the registered target only.
    always_comb begin
        tick       = (slew_cnt == SLEW_LAST);
        slew_next  = tick ? '0 : slew_cnt + 32'd1;
        value_next = value;
        if (tick) begin
            if (value < target) begin
                value_next = value + 32'd1;
            end else if (value > target) begin
                value_next = value - 32'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            target    <= SAFE;
            value     <= SAFE;
            at_target <= 1'b1;
            clamped   <= 1'b0;
            fault     <= 1'b0;
            wd_cnt    <= '0;
            slew_cnt  <= '0;
        end else begin
            state     <= state_next;
            target    <= target_next;
            value     <= value_next;
            at_target <= (value == target);
            clamped   <= clamped_next;
            fault     <= fault_next;
            wd_cnt    <= wd_next;
            slew_cnt  <= slew_next;
        end
    end

endmodule

// File: doc/vout_udpoti_setpoint.md
# vout_udpoti_setpoint

Setpoint conditioning stage directly upstream of the up/down digital-potentiometer driver. Accepts raw signed 32-bit setpoints from the host interface with a write strobe and clamps them to the pot range. Applies a deadband and a slew-rate limit, and drives a safe value if the host stops writing. Its `value` output feeds the driver's `value` input unchanged.

## Interface
- `RESOLUTION`, 100: pot step count; legal output range is 0..RESOLUTION.
- `SLEW_DIV`, 200000: clocks per one-count output step; minimum 1.
- `DEADBAND`, 0: a new target is accepted only if it differs from the current target by more than this.
- `TIMEOUT`, 50000000: clocks without a strobe before fault; 0 disables the watchdog.
- `SAFE_VALUE`, 0: target while in fault and at reset; must be ≤ RESOLUTION.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `setpoint` in 32: host setpoint, two's-complement signed.
- `setpoint_valid` in 1: one-cycle write strobe; `setpoint` is sampled when this is high.
- `value` out 32: conditioned position to the pot driver.
- `at_target` out 1: high when `value == target`.
- `clamped` out 1: high when the last accepted write was saturated.
- `fault` out 1: watchdog expired; safe value is being applied.

## Operation
- Reset (async assert, sync release): `value = target = SAFE_VALUE`, `at_target = 1`, `clamped = 0`, `fault = 0`, watchdog counter = 0, slew counter = 0, state RUN.
- Clamp: `sat = 0` if setpoint < 0 (signed compare); `sat = RESOLUTION` if setpoint > RESOLUTION; otherwise `sat = setpoint`. `clamped_next = (sat != setpoint)`.
- Deadband: on a strobe in RUN, `target ← sat` and `clamped ← clamped_next` only if `|sat − target| > DEADBAND`. Compute the difference as 33-bit unsigned magnitude. Otherwise target and `clamped` are unchanged.
- States:
  - RUN: the watchdog counter increments each clock and is cleared on any strobe. When the counter reaches TIMEOUT (TIMEOUT ≠ 0) with no strobe that cycle: go to FAULT, `target ← SAFE_VALUE`, `fault ← 1`.
  - FAULT: `fault = 1`. The next strobe returns to RUN and loads `target ← sat` unconditionally, bypassing the deadband. `fault ← 0` and the watchdog clears.
- Simultaneous strobe and expiry in the same cycle: the strobe wins; no fault.
- Slew:
  - The slew counter counts 0..SLEW_DIV−1 continuously. On the wrap cycle (the tick), `value` moves one count toward `target` if they differ.
  - The step compares against the target register's current contents; a target written in the same cycle takes effect from the next tick.
  - `value` never overshoots and never leaves 0..RESOLUTION.
- If the target reverses mid-ramp, the ramp reverses on the next tick with no extra delay.
- Signals are registered; no combinational path from inputs to outputs.

## Timing
- A strobe at cycle N updates `target`, `clamped` and `fault` at edge N+1.
- The first `value` change occurs at the first tick after N+1; worst-case latency is SLEW_DIV clocks.
- `at_target` is registered and reflects `value == target` one cycle after either changes.
- Ramp duration for a difference D is D × SLEW_DIV clocks, ±1 tick phase.
- The watchdog asserts `fault` TIMEOUT clocks after the last strobe (cycle last+TIMEOUT+1).
- `rst` mid-ramp: all outputs return to their reset values immediately (async). The ramp does not resume.
- Slew counter phase is free-running and is not resynchronised by strobes.

## Test plan
- Reset, then strobe setpoint=40 (SLEW_DIV=4, DEADBAND=0, TIMEOUT=0) → `target` = 40 next cycle; `value` increments every 4 clocks to reach 40 after 160±4 clocks; `at_target` rises 1 cycle after arrival; `clamped` = 0.
- Clamp: strobe −5 → target 0, `clamped` = 1. Strobe 250 (RESOLUTION=100) → target 100, `clamped` = 1. Strobe 0x8000_0000 → target 0.
- Deadband=3, target=50: strobe 53 → ignored. Strobe 54 → target 54. Strobe 51 → ignored, `clamped` unchanged.
- Reversal: ramping 0→80; at value=30, strobe 10 → next tick value=29, ramp settles at 10 without overshoot.
- Watchdog (TIMEOUT=100, SAFE_VALUE=5, target=60): no strobe for 100 clocks → `fault` = 1, ramp to 5. A strobe at exactly the expiry cycle → no fault. In FAULT, strobe 6 with DEADBAND=3 → target 6 (bypass), `fault` = 0.
- `rst` pulse mid-ramp (value=37) → `value` = SAFE_VALUE, `fault` = 0 and `at_target` = 1 without a clock edge; no steps until a new strobe is received.
